temp_sensor_reader: RTL and testbench

Serial front end that reads the 4-bit raw value from the external temperature sensor and presents it as `tempSensorValue` to the temperature abnormality detector. It is the reading side of the sensor link: it drives chip-select and a divided serial clock, shifts in a parity-protected frame, checks it, and publishes the value with a one-cycle valid strobe. Optional 4-sample averaging smooths the published value.

---
 rtl/temp_sensor_reader.sv | 164 ++++++++++++++++
 tb/tb_temp_sensor_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_reader.sv
// Serial reader for the 4-bit temperature sensor: parity-checked frame, valid/err strobes.
// Define TEMP_SENSOR_AVG_EN to publish the average of the last 4 good samples.
module temp_sensor_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sampleReq,
  input  logic       sensorData,
  output logic       sensorCsN,
  output logic       sensorClk,
  output logic [3:0] tempSensorValue,
  output logic       sampleValid,
  output logic       sampleErr,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    stateNxt;
  logic [CW-1:0] divCnt;
  logic [CW-1:0] divCntNxt;
  logic [2:0]    bitIdx;
  logic [2:0]    bitIdxNxt;
  logic          phaseHigh;
  logic          phaseHighNxt;
  logic [4:0]    shiftReg;
  logic          cntZero;
  logic          frameActive;
  logic          sclkNxt;
  logic          frameOk;
  logic          acceptGood;
  logic [3:0]    rawValue;
  logic [3:0]    newValue;

  assign cntZero     = (divCnt == '0);
  assign frameActive = (state == SETUP) || (state == SHIFT);
  assign sclkNxt     = (state == SHIFT) && phaseHigh;
  assign frameOk     = ~^shiftReg;
  assign acceptGood  = (state == DONE) && frameOk;
  assign rawValue    = shiftReg[4:1];

  always_comb begin
    stateNxt     = state;
    divCntNxt    = divCnt;
    bitIdxNxt    = bitIdx;
    phaseHighNxt = phaseHigh;
    unique case (state)
      IDLE: begin
        if (sampleReq) begin
          stateNxt  = SETUP;
          divCntNxt = RELOAD;
        end
      end
      SETUP: begin
        if (cntZero) begin
          stateNxt     = SHIFT;
          divCntNxt    = RELOAD;
          bitIdxNxt    = '0;
          phaseHighNxt = 1'b0;
        end else begin
          divCntNxt = divCnt - 1'b1;
        end
      end
      SHIFT: begin
        if (!cntZero) begin
          divCntNxt = divCnt - 1'b1;
        end else if (!phaseHigh) begin
          phaseHighNxt = 1'b1;
          divCntNxt    = RELOAD;
        end else if (bitIdx == 3'd4) begin
          stateNxt     = DONE;
          phaseHighNxt = 1'b0;
          divCntNxt    = '0;
        end else begin
          bitIdxNxt    = bitIdx + 3'd1;
          phaseHighNxt = 1'b0;
          divCntNxt    = RELOAD;
        end
      end
      DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // Pins are registered from the current state, so they trail it by one clk.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      divCnt          <= '0;
      bitIdx          <= '0;
      phaseHigh       <= 1'b0;
      shiftReg        <= '0;
      sensorCsN       <= 1'b1;
      sensorClk       <= 1'b0;
      busy            <= 1'b0;
      sampleValid     <= 1'b0;
      sampleErr       <= 1'b0;
      tempSensorValue <= '0;
    end else begin
      state       <= stateNxt;
      divCnt      <= divCntNxt;
      bitIdx      <= bitIdxNxt;
      phaseHigh   <= phaseHighNxt;
      sensorCsN   <= !frameActive;
      sensorClk   <= sclkNxt;
      busy        <= frameActive;
      sampleValid <= acceptGood;
      sampleErr   <= (state == DONE) && !frameOk;
      if (sclkNxt && !sensorClk) begin
        shiftReg <= {shiftReg[3:0], sensorData};
      end
      if (acceptGood) begin
        tempSensorValue <= newValue;
      end
    end
  end

`ifdef TEMP_SENSOR_AVG_EN
  logic [3:0][3:0] hist;
  logic            histValid;
  logic [5:0]      histSum;

  // hist[0] is newest; the incoming sample replaces hist[3] in the sum.
  always_comb begin
    if (!histValid) begin
      histSum = {rawValue, 2'b00};
    end else begin
      histSum = {2'b00, rawValue} + {2'b00, hist[0]}
              + {2'b00, hist[1]} + {2'b00, hist[2]};
    end
  end

  assign newValue = histSum[5:2];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hist      <= '0;
      histValid <= 1'b0;
    end else if (acceptGood) begin
      histValid <= 1'b1;
      if (!histValid) begin
        hist <= {4{rawValue}};
      end else begin
        hist <= {hist[2], hist[1], hist[0], rawValue};
      end
    end
  end
`else
  assign newValue = rawValue;
`endif

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: CLK_DIV=4 and CLK_DIV=1 instances against a timeline model.
// Sensor models shift frame bits out MSB first, one per sensorClk rise.
module tb_temp_sensor_reader;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] sd;
  logic [1:0] csN;
  logic [1:0] sclk;
  logic [1:0] sValid;
  logic [1:0] sErr;
  logic [1:0] bsy;
  logic [3:0] val [2];
  logic [4:0] frame [2];

  int  tests = 0;
  int  fails = 0;
  bit  chk = 1'b0;
  int  cyc = 0;
  int  lowCnt [2];
  int  riseCnt [2];
  int  vCnt [2];
  int  eCnt [2];
  logic prevS [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    logic [2:0] bc = '0;
    temp_sensor_reader #(.CLK_DIV(g == 0 ? 4 : 1)) u (
      .clk(clk),
      .resetN(resetN),
      .sampleReq(req[g]),
      .sensorData(sd[g]),
      .sensorCsN(csN[g]),
      .sensorClk(sclk[g]),
      .tempSensorValue(val[g]),
      .sampleValid(sValid[g]),
      .sampleErr(sErr[g]),
      .busy(bsy[g])
    );
    always @(posedge sclk[g] or posedge csN[g]) begin
      if (csN[g]) bc <= '0;
      else bc <= bc + 3'd1;
    end
    assign sd[g] = (bc < 3'd5) ? frame[g][3'd4 - bc] : 1'b0;
  end

  // Timeline model: a frame accepted at edge s keeps CS low on edges
  // s+1..s+11d, strobes on edge s+11d+1, and frees the reader after that.
  bit          act [2];
  int          st [2];
  logic [4:0]  fr [2];
  logic [15:0] hist [2];
  bit          hv [2];
  logic        eCsN [2];
  logic        eSclk [2];
  logic        eBusy [2];
  logic        eValid [2];
  logic        eErr [2];
  logic [3:0]  eVal [2];

  function automatic logic [3:0] avg4(input logic [15:0] h);
    automatic int s = int'(h[3:0]) + int'(h[7:4]) + int'(h[11:8]) + int'(h[15:12]);
    return 4'(s / 4);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      automatic int d = (k == 0) ? 4 : 1;
      automatic int e = cyc + 1;
      automatic bit a = act[k];
      automatic int s = st[k];
      automatic logic [4:0] f = fr[k];
      automatic logic [3:0] v = eVal[k];
      automatic logic [15:0] h = hist[k];
      automatic bit hvl = hv[k];
      automatic int t;
      automatic bit strobe;
      automatic bit good;
      automatic bit low;
      if (!resetN) begin
        a = 1'b0;
        v = 4'h0;
        h = '0;
        hvl = 1'b0;
      end else begin
        if (a && e >= s + 11 * d + 2) a = 1'b0;
        if (!a && req[k]) begin
          a = 1'b1;
          s = e;
          f = frame[k];
        end
      end
      strobe = a && (e == s + 11 * d + 1);
      good = ~^f;
      low = a && e >= s + 1 && e <= s + 11 * d;
      t = e - s - 1 - d;
      if (strobe && good) begin
`ifdef TEMP_SENSOR_AVG_EN
        h = hvl ? {h[11:0], f[4:1]} : {4{f[4:1]}};
        hvl = 1'b1;
        v = avg4(h);
`else
        v = f[4:1];
`endif
      end
      act[k]    <= a;
      st[k]     <= s;
      fr[k]     <= f;
      hist[k]   <= h;
      hv[k]     <= hvl;
      eCsN[k]   <= !low;
      eBusy[k]  <= low;
      eSclk[k]  <= a && t >= 0 && t < 10 * d && (t % (2 * d)) >= d;
      eValid[k] <= strobe && good;
      eErr[k]   <= strobe && !good;
      eVal[k]   <= v;
    end
  end

  task automatic cmpAll();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({csN[k], sclk[k], bsy[k], sValid[k], sErr[k], val[k]} !==
          {eCsN[k], eSclk[k], eBusy[k], eValid[k], eErr[k], eVal[k]}) begin
        fails++;
        if (fails < 40)
          $display("FAIL model[%0d] cyc %0d: got cs=%b sclk=%b busy=%b v=%b e=%b val=%h expected cs=%b sclk=%b busy=%b v=%b e=%b val=%h",
                   k, cyc, csN[k], sclk[k], bsy[k], sValid[k], sErr[k], val[k],
                   eCsN[k], eSclk[k], eBusy[k], eValid[k], eErr[k], eVal[k]);
      end
      if (csN[k] === 1'b0) lowCnt[k]++;
      if (sclk[k] === 1'b1 && prevS[k] === 1'b0) riseCnt[k]++;
      if (sValid[k] === 1'b1) vCnt[k]++;
      if (sErr[k] === 1'b1) eCnt[k]++;
      prevS[k] = sclk[k];
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clearCnt(input int k);
    lowCnt[k] = 0;
    riseCnt[k] = 0;
    vCnt[k] = 0;
    eCnt[k] = 0;
  endtask

  function automatic logic [4:0] mk(input logic [3:0] v, input bit good);
    return {v, good ? ^v : ~^v};
  endfunction

  task automatic pulseReq(input int k);
    req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  task automatic waitStrobe(input int k);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (sValid[k] === 1'b1 || sErr[k] === 1'b1) got = 1'b1;
    end
    check("strobe_timeout", 32'(got), 32'd1);
  endtask

  task automatic runFrame(input int k, input logic [4:0] f);
    frame[k] = f;
    pulseReq(k);
    waitStrobe(k);
    @(negedge clk);
  endtask

  logic [3:0] seqV [4];
  bit         seqG [4];
  logic [3:0] seqE [4];
  logic [3:0] avV [5];
  bit         avG [5];
  logic [3:0] avE [5];
  int         prevCyc;

  initial begin
    frame[0] = '0;
    frame[1] = '0;
    for (int k = 0; k < 2; k++) begin
      clearCnt(k);
      prevS[k] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        if (chk) cmpAll();
      end
    join_none

    repeat (3) @(negedge clk);
    chk = 1'b1;
    check("rst_csN0", 32'(csN[0]), 32'd1);
    check("rst_sclk0", 32'(sclk[0]), 32'd0);
    check("rst_busy1", 32'(bsy[1]), 32'd0);
    check("rst_val0", 32'(val[0]), 32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    clearCnt(0);
    runFrame(0, 5'b10100);
    check("f1_val", 32'(val[0]), 32'hA);
    check("f1_low", 32'(lowCnt[0]), 32'd44);
    check("f1_rise", 32'(riseCnt[0]), 32'd5);
    check("f1_valid", 32'(vCnt[0]), 32'd1);
    check("f1_err", 32'(eCnt[0]), 32'd0);

    runFrame(0, mk(4'h3, 1'b1));
    check("good3_val", 32'(val[0]), 32'h3);
    clearCnt(0);
    runFrame(0, 5'b01110);
    check("bad_err", 32'(eCnt[0]), 32'd1);
    check("bad_valid", 32'(vCnt[0]), 32'd0);
    check("bad_hold", 32'(val[0]), 32'h3);

    clearCnt(0);
    frame[0] = mk(4'hC, 1'b1);
    pulseReq(0);
    @(negedge clk);
    pulseReq(0);
    repeat (17) @(negedge clk);
    pulseReq(0);
    waitStrobe(0);
    check("ign_val", 32'(val[0]), 32'hC);
    frame[0] = mk(4'h5, 1'b1);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    check("b2b_cs_pre", 32'(csN[0]), 32'd1);
    @(negedge clk);
    check("b2b_cs_low", 32'(csN[0]), 32'd0);
    waitStrobe(0);
    @(negedge clk);
    check("b2b_val", 32'(val[0]), 32'h5);
    repeat (60) @(negedge clk);
    check("ign_strobes", 32'(vCnt[0]), 32'd2);
    check("ign_err", 32'(eCnt[0]), 32'd0);

    clearCnt(0);
    frame[0] = mk(4'h6, 1'b1);
    pulseReq(0);
    repeat (18) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    check("mid_rst_cs", 32'(csN[0]), 32'd1);
    check("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_rst_nostrobe", 32'(vCnt[0] + eCnt[0]), 32'd0);
    check("mid_rst_val", 32'(val[0]), 32'd0);
    clearCnt(0);
    runFrame(0, mk(4'h9, 1'b1));
    check("post_rst_val", 32'(val[0]), 32'h9);
    check("post_rst_low", 32'(lowCnt[0]), 32'd44);
    check("post_rst_rise", 32'(riseCnt[0]), 32'd5);

    seqV = '{4'h1, 4'hE, 4'h7, 4'h6};
    seqG = '{1'b1, 1'b1, 1'b0, 1'b1};
    seqE = '{4'h1, 4'hE, 4'hE, 4'h6};
    clearCnt(1);
    frame[1] = mk(seqV[0], seqG[0]);
    pulseReq(1);
    waitStrobe(1);
    prevCyc = cyc;
    check("d1_val0", 32'(val[1]), 32'(seqE[0]));
    for (int i = 1; i < 4; i++) begin
      frame[1] = mk(seqV[i], seqG[i]);
      req[1] = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
      waitStrobe(1);
      check("d1_spacing", 32'(cyc - prevCyc), 32'd13);
      check("d1_val", 32'(val[1]), 32'(seqE[i]));
      prevCyc = cyc;
    end
    @(negedge clk);
    check("d1_valid", 32'(vCnt[1]), 32'd3);
    check("d1_err", 32'(eCnt[1]), 32'd1);
    check("d1_low", 32'(lowCnt[1]), 32'd44);
    check("d1_rise", 32'(riseCnt[1]), 32'd20);

    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    avV = '{4'h8, 4'h4, 4'h2, 4'h4, 4'h0};
    avG = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef TEMP_SENSOR_AVG_EN
    avE = '{4'h8, 4'h7, 4'h7, 4'h6, 4'h4};
`else
    avE = '{4'h8, 4'h4, 4'h4, 4'h4, 4'h0};
`endif
    for (int i = 0; i < 5; i++) begin
      runFrame(0, mk(avV[i], avG[i]));
      check("avg_val", 32'(val[0]), 32'(avE[i]));
    end

    repeat (5) @(negedge clk);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
